ps2_key_decoder: RTL and testbench

//  PS/2 keyboard receiver, fully synchronous to the system clock. PS/2 clock/data are sampled, not used as clocks.

---
 rtl/ps2_key_decoder_pkg.sv | 31 +++
 rtl/ps2_evt_fifo.sv | 53 +++++
 rtl/ps2_key_decoder.sv | 236 +++++++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_key_decoder_pkg.sv
// Shared PS/2 definitions: protocol byte values, frame FSM states, event payload.
package ps2_key_decoder_pkg;

  // Protocol bytes with special meaning to the decoder
  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;
  localparam logic [7:0] PS2_ERR0    = 8'h00;
  localparam logic [7:0] PS2_ERR1    = 8'hFF;

  // Event payload width: {ext, brk, code}
  localparam int unsigned EVT_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

  // PS/2 uses odd parity: data plus parity bit must hold an odd number of ones
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Synchronous first-word-fall-through FIFO for PS/2 key events.
// Ports: clk, rst (sync, active-high), push/wdata write side, pop read side,
//        rdata_c (head entry), full_c, empty_c (combinational status from pointers).
// A push while full is only accepted when a pop happens in the same cycle.
module ps2_evt_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata_c,
  output logic             full_c,
  output logic             empty_c
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match
  assign empty_c = (wr_ptr == rd_ptr);
  assign full_c  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty_c;
  assign do_push = push && (!full_c || do_pop);
  assign rdata_c = mem[rd_ptr[AW-1:0]];

  // Pointer and storage update
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver running entirely on the system clock.
// Ports: clk, rst (sync, active-high); ps2_clk/ps2_data raw pins;
//        ev_valid/ev_ready/ev_code/ev_ext/ev_break event stream (FWFT FIFO head);
//        key_down held bitmap for KEY_CODES; parity_err/frame_err/overflow 1-cycle pulses.
module ps2_key_decoder
  import ps2_key_decoder_pkg::*;
#(
  parameter int unsigned               FILTER_LEN     = 4,
  parameter int unsigned               TIMEOUT_CYCLES = 100000,
  parameter int unsigned               FIFO_DEPTH     = 8,
  parameter int unsigned               NUM_KEYS       = 2,
  parameter logic [9*NUM_KEYS-1:0]     KEY_CODES      = {9'h02D, 9'h024}
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ps2_clk,
  input  logic                ps2_data,
  output logic                ev_valid,
  input  logic                ev_ready,
  output logic [7:0]          ev_code,
  output logic                ev_ext,
  output logic                ev_break,
  output logic [NUM_KEYS-1:0] key_down,
  output logic                parity_err,
  output logic                frame_err,
  output logic                overflow
);

  localparam int unsigned FW = 4;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  // Synchroniser stages; idle-high pins reset to 1 so no fall is seen out of reset
  logic clk_s1, clk_s2, data_s1, data_s2;

  // Glitch filter
  logic          filt_clk;
  logic          filt_prev;
  logic [FW-1:0] filt_cnt;
  logic          fall;

  // Frame receiver
  frame_state_t  state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par_bit;
  logic [TW-1:0] tmo_cnt;
  logic          byte_vld;
  logic          tmo_abort;

  // Prefix decoder and event path
  logic     ext_q;
  logic     brk_q;
  logic     push_vld;
  ps2_evt_t push_evt;
  ps2_evt_t head_evt;
  logic     fifo_full;
  logic     fifo_empty;
  logic     pop;

  // Two-flop synchronisers on both pins
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= ps2_clk;
      clk_s2  <= clk_s1;
      data_s1 <= ps2_data;
      data_s2 <= data_s1;
    end
  end

  // Accept a ps2_clk level change only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_clk  <= 1'b1;
      filt_prev <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      filt_prev <= filt_clk;
      if (clk_s2 != filt_clk) begin
        if (filt_cnt == FW'(FILTER_LEN - 1)) begin
          filt_clk <= clk_s2;
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + 1'b1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  assign fall = filt_prev & ~filt_clk;

  // Frame FSM: start, 8 data bits LSB first, parity, stop; timeout aborts a stalled frame
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      par_bit    <= 1'b0;
      tmo_cnt    <= '0;
      byte_vld   <= 1'b0;
      tmo_abort  <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_vld   <= 1'b0;
      tmo_abort  <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (fall && !data_s2) begin
            state   <= ST_DATA;
            bit_cnt <= '0;
          end
        end
        ST_DATA: begin
          if (fall) begin
            shift   <= {data_s2, shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
              state <= ST_PARITY;
            end
          end
        end
        ST_PARITY: begin
          if (fall) begin
            par_bit <= data_s2;
            state   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (fall) begin
            state <= ST_IDLE;
            if (!odd_parity_ok(shift, par_bit)) begin
              parity_err <= 1'b1;
            end else if (!data_s2) begin
              frame_err <= 1'b1;
            end else begin
              byte_vld <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Cycles since the last fall; only meaningful while a frame is open
      if (state == ST_IDLE || fall) begin
        tmo_cnt <= '0;
      end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        tmo_cnt   <= '0;
        state     <= ST_IDLE;
        frame_err <= 1'b1;
        tmo_abort <= 1'b1;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

  // Fold E0/F0 prefixes into one event; update the held-key bitmap alongside
  always_ff @(posedge clk) begin
    if (rst) begin
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
      push_vld <= 1'b0;
      push_evt <= '0;
      key_down <= '0;
    end else begin
      push_vld <= 1'b0;
      if (tmo_abort) begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end else if (byte_vld) begin
        case (shift)
          PS2_PFX_EXT: ext_q <= 1'b1;
          PS2_PFX_BRK: brk_q <= 1'b1;
          PS2_ERR0, PS2_ERR1: begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
          end
          default: begin
            push_vld      <= 1'b1;
            push_evt.ext  <= ext_q;
            push_evt.brk  <= brk_q;
            push_evt.code <= shift;
            ext_q         <= 1'b0;
            brk_q         <= 1'b0;
            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
              if ({ext_q, shift} == KEY_CODES[9*i +: 9]) begin
                key_down[i] <= ~brk_q;
              end
            end
          end
        endcase
      end
    end
  end

  assign ev_valid = ~fifo_empty;
  assign pop      = ev_valid & ev_ready;

  ps2_evt_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_vld),
    .wdata   (push_evt),
    .pop     (pop),
    .rdata_c (head_evt),
    .full_c  (fifo_full),
    .empty_c (fifo_empty)
  );

  assign ev_code  = head_evt.code;
  assign ev_ext   = head_evt.ext;
  assign ev_break = head_evt.brk;

  // A write is lost only when the FIFO is full and nothing leaves in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else begin
      overflow <= push_vld & fifo_full & ~pop;
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: bit-banged PS/2 frames, event scoreboard, pulse counters.
module tb_ps2_key_decoder;

  localparam int unsigned TMO = 400;
  localparam int unsigned HP  = 200;  // PS/2 half bit period in ns

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic       ev_ready;
  logic       ev_valid;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_break;
  logic [1:0] key_down;
  logic       parity_err;
  logic       frame_err;
  logic       overflow;

  int checks = 0;
  int passed = 0;
  int par_cnt = 0;
  int frm_cnt = 0;
  int ovf_cnt = 0;
  logic [9:0] evq[$];

  ps2_key_decoder #(
    .FILTER_LEN     (4),
    .TIMEOUT_CYCLES (TMO),
    .FIFO_DEPTH     (8),
    .NUM_KEYS       (2),
    .KEY_CODES      ({9'h02D, 9'h024})
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_code    (ev_code),
    .ev_ext     (ev_ext),
    .ev_break   (ev_break),
    .key_down   (key_down),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Pulse counters and popped-event log
  always @(posedge clk) begin
    if (parity_err) par_cnt++;
    if (frame_err)  frm_cnt++;
    if (overflow)   ovf_cnt++;
    if (!rst && ev_valid && ev_ready) evq.push_back({ev_ext, ev_break, ev_code});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic expect_ev(input string tag, input logic [9:0] exp);
    check({tag, "_present"}, 32'(evq.size() > 0), 32'd1);
    if (evq.size() > 0) check(tag, 32'(evq.pop_front()), 32'(exp));
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    #(HP / 2);
    ps2_clk = 1'b0;
    #(HP);
    ps2_clk = 1'b1;
    #(HP / 2);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_bit(1'b1);
    ps2_data = 1'b1;
    #(2 * HP);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int p0, f0, o0;
    logic seen;
    logic [7:0] t4_codes [9];
    t4_codes = '{8'h15, 8'h1D, 8'h24, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44, 8'h4B};

    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; ev_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ev_valid",   32'(ev_valid),   32'd0);
    check("rst_key_down",   32'(key_down),   32'd0);
    check("rst_parity_err", 32'(parity_err), 32'd0);
    check("rst_frame_err",  32'(frame_err),  32'd0);
    check("rst_overflow",   32'(overflow),   32'd0);
    check("rst_ev_code",    32'(ev_code),    32'd0);

    // 1: single make of watched key 0x24
    p0 = par_cnt; f0 = frm_cnt;
    send_frame(8'h24, 1'b0);
    expect_ev("t1_ev", {1'b0, 1'b0, 8'h24});
    check("t1_key_down", 32'(key_down), 32'd1);
    check("t1_par", 32'(par_cnt - p0), 32'd0);
    check("t1_frm", 32'(frm_cnt - f0), 32'd0);
    check("t1_empty", 32'(ev_valid), 32'd0);

    // 2: break of 0x24, then extended make E0 75
    send_frame(8'hF0, 1'b0);
    send_frame(8'h24, 1'b0);
    send_frame(8'hE0, 1'b0);
    send_frame(8'h75, 1'b0);
    expect_ev("t2_brk", {1'b0, 1'b1, 8'h24});
    expect_ev("t2_ext", {1'b1, 1'b0, 8'h75});
    check("t2_key_down", 32'(key_down), 32'd0);
    check("t2_empty", 32'(ev_valid), 32'd0);
    check("t2_qlen", 32'(evq.size()), 32'd0);

    // 3: bad parity frame dropped, then the good one decodes
    p0 = par_cnt;
    send_frame(8'h2D, 1'b1);
    check("t3_par", 32'(par_cnt - p0), 32'd1);
    check("t3_noev", 32'(evq.size()), 32'd0);
    check("t3_key_keep", 32'(key_down), 32'd0);
    send_frame(8'h2D, 1'b0);
    expect_ev("t3_ev", {1'b0, 1'b0, 8'h2D});
    check("t3_key_down", 32'(key_down), 32'd2);

    // 4: fill FIFO with ready low, overflow on the ninth event
    #1 ev_ready = 1'b0;
    o0 = ovf_cnt;
    for (int i = 0; i < 8; i++) send_frame(t4_codes[i], 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h2D, 1'b0);
    check("t4_ovf", 32'(ovf_cnt - o0), 32'd1);
    check("t4_key_down", 32'(key_down), 32'd1);
    check("t4_valid", 32'(ev_valid), 32'd1);
    check("t4_head", 32'(ev_code), 32'h15);
    check("t4_qlen0", 32'(evq.size()), 32'd0);

    // Pop exactly in the cycle the next event is written while full
    seen = 1'b0;
    fork
      send_frame(8'h4B, 1'b0);
      begin
        repeat (3000) begin
          @(negedge clk);
          if (dut.push_vld) begin
            seen = 1'b1;
            break;
          end
        end
        if (seen) begin
          ev_ready = 1'b1;
          @(posedge clk);
          #1 ev_ready = 1'b0;
        end
      end
    join
    check("t4_push_seen", 32'(seen), 32'd1);
    check("t4_no_ovf", 32'(ovf_cnt - o0), 32'd1);
    check("t4_qlen1", 32'(evq.size()), 32'd1);
    #1 ev_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    for (int i = 0; i < 9; i++) expect_ev($sformatf("t4_ev%0d", i), {2'b00, t4_codes[i]});
    check("t4_drained", 32'(ev_valid), 32'd0);

    // 5: stall ps2_clk after 4 data bits, expect timeout abort then clean frame
    f0 = frm_cnt; p0 = par_cnt;
    ps2_bit(1'b0);
    ps2_bit(1'b0); ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
    ps2_data = 1'b1;
    #(TMO * 10 + 1000);
    check("t5_frm", 32'(frm_cnt - f0), 32'd1);
    check("t5_noev", 32'(evq.size()), 32'd0);
    send_frame(8'h1C, 1'b0);
    expect_ev("t5_ev", {1'b0, 1'b0, 8'h1C});
    check("t5_frm_after", 32'(frm_cnt - f0), 32'd1);
    check("t5_par", 32'(par_cnt - p0), 32'd0);

    // 6: reset mid-frame after an E0 prefix, glitch on ps2_clk, then 0x6B
    send_frame(8'hE0, 1'b0);
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("t6_rst_key", 32'(key_down), 32'd0);
    check("t6_rst_valid", 32'(ev_valid), 32'd0);
    ps2_data = 1'b1;
    #(2 * HP);
    ps2_data = 1'b0;
    @(posedge clk);
    #2 ps2_clk = 1'b0;
    #10 ps2_clk = 1'b1;
    #(HP);
    ps2_data = 1'b1;
    #(HP);
    f0 = frm_cnt;
    evq.delete();
    send_frame(8'h6B, 1'b0);
    expect_ev("t6_ev", {1'b0, 1'b0, 8'h6B});
    check("t6_frm", 32'(frm_cnt - f0), 32'd0);
    check("t6_key_down", 32'(key_down), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
